// File: rtl/mips_cpu_hilo_unit.sv
// HI/LO register unit: single-cycle MULT/MULTU/MTHI/MTLO and
// iterative restoring DIV/DIVU with busy stall and done pulse.
module mips_cpu_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    DIV_RUN,
    DIV_FIX
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic             qneg, rneg, dz;

  logic accept;
  logic is_mult, is_multu, is_div, is_divu;
  logic is_mthi, is_mtlo, is_dv;

  assign accept   = op_valid && (state == IDLE);
  assign is_mult  = accept && (op == 3'd0);
  assign is_multu = accept && (op == 3'd1);
  assign is_div   = accept && (op == 3'd2);
  assign is_divu  = accept && (op == 3'd3);
  assign is_mthi  = accept && (op == 3'd4);
  assign is_mtlo  = accept && (op == 3'd5);
  assign is_dv    = is_div || is_divu;

  logic [2*WIDTH-1:0] sprod, uprod;

  assign sprod = {{WIDTH{rs_data[WIDTH-1]}}, rs_data}
               * {{WIDTH{rt_data[WIDTH-1]}}, rt_data};
  assign uprod = {{WIDTH{1'b0}}, rs_data}
               * {{WIDTH{1'b0}}, rt_data};

  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign rs_neg = is_div && rs_data[WIDTH-1];
  assign rt_neg = is_div && rt_data[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_data : rs_data;
  assign rt_mag = rt_neg ? -rt_data : rt_data;

  // One restoring step: shift next dividend bit into the remainder
  logic [WIDTH:0] sh, diff;
  logic           ge;

  assign sh   = {rem, quo[WIDTH-1]};
  assign diff = sh - {1'b0, dvs};
  assign ge   = (sh >= {1'b0, dvs});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (is_dv) state_nx = DIV_RUN;
      DIV_RUN: if (cnt == '0) state_nx = DIV_FIX;
      DIV_FIX: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      dz   <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_nx != IDLE);
      unique case (1'b1)
        is_mult: begin
          {hi, lo} <= sprod;
          done     <= 1'b1;
        end
        is_multu: begin
          {hi, lo} <= uprod;
          done     <= 1'b1;
        end
        is_mthi: begin
          hi   <= rs_data;
          done <= 1'b1;
        end
        is_mtlo: begin
          lo   <= rs_data;
          done <= 1'b1;
        end
        is_dv: begin
          quo  <= rs_mag;
          dvs  <= rt_mag;
          rem  <= '0;
          cnt  <= CW'(WIDTH - 1);
          qneg <= rs_neg ^ rt_neg;
          rneg <= rs_neg;
          dz   <= (rt_data == '0);
        end
        (state == DIV_RUN): begin
          rem <= ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ge};
          cnt <= cnt - CW'(1);
        end
        (state == DIV_FIX): begin
          // Zero divisor keeps the all-ones quotient unsigned
          lo   <= (qneg && !dz) ? -quo : quo;
          hi   <= rneg ? -rem : rem;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// Randomized self-checking bench for mips_cpu_hilo_unit against
// an arithmetic reference model of HI/LO.
module tb_mips_cpu_hilo_unit;

  localparam int W = 32;

  logic         clk, reset, op_valid, busy, done;
  logic [2:0]   op;
  logic [W-1:0] rs_data, rt_data, hi, lo;

  int ncmp, nerr, cyc, d1, d2, n;
  logic [W-1:0] mhi, mlo;

  mips_cpu_hilo_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] o,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int sa, sb;
    longint p, q, r;
    longint unsigned pu;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin
        p = longint'(sa) * longint'(sb);
        mhi = p[63:32];
        mlo = p[31:0];
      end
      3'd1: begin
        pu = {32'b0, a} * {32'b0, b};
        mhi = pu[63:32];
        mlo = pu[31:0];
      end
      3'd2, 3'd3: begin
        if (b == 0) begin
          mlo = 32'hFFFF_FFFF;
          mhi = a;
        end else if (o == 3'd3) begin
          mlo = a / b;
          mhi = a % b;
        end else begin
          q = longint'(sa) / longint'(sb);
          r = longint'(sa) % longint'(sb);
          mlo = q[31:0];
          mhi = r[31:0];
        end
      end
      3'd4: mhi = a;
      3'd5: mlo = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] o,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    op_valid = 1'b1;
    op       = o;
    rs_data  = a;
    rt_data  = b;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic run_fast(input logic [2:0] o,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b);
    issue(o, a, b);
    model(o, a, b);
    check("fast_done", 32'(done), 32'd1);
    check("fast_busy", 32'(busy), 32'd0);
    check("fast_hi", hi, mhi);
    check("fast_lo", lo, mlo);
  endtask

  task automatic run_div(input logic [2:0] o,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input bit inject);
    issue(o, a, b);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (inject && n == 10) begin
        op_valid = 1'b1;
        op       = 3'd5;
        rs_data  = 32'hCAFE_0001;
      end else begin
        op_valid = 1'b0;
      end
      @(negedge clk);
    end
    op_valid = 1'b0;
    model(o, a, b);
    check("div_busy_cycles", 32'(n), 32'(W + 1));
    check("div_done", 32'(done), 32'd1);
    check("div_hi", hi, mhi);
    check("div_lo", lo, mlo);
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    reset = 1'b1;
    op_valid = 1'b0;
    op = 3'd0;
    rs_data = '0;
    rt_data = '0;
    mhi = '0;
    mlo = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_fast(3'd0, 32'hFFFF_FFFD, 32'd5);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFF1);
    run_fast(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi_const", hi, 32'hFFFF_FFFE);
    check("multu_lo_const", lo, 32'h0000_0001);

    run_div(3'd3, 32'd100, 32'd7, 1'b0);
    check("divu_lo_const", lo, 32'd14);
    check("divu_hi_const", hi, 32'd2);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    run_div(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);
    run_div(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);
    run_div(3'd3, 32'h1234, 32'd0, 1'b0);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 32'h1234);
    run_div(3'd2, 32'hFFFF_FF00, 32'd0, 1'b0);

    run_fast(3'd4, 32'hDEAD_BEEF, 32'd0);
    run_fast(3'd5, 32'h0BAD_F00D, 32'd0);
    check("mt_hi_const", hi, 32'hDEAD_BEEF);
    check("mt_lo_const", lo, 32'h0BAD_F00D);

    run_div(3'd3, 32'd1000, 32'd9, 1'b1);
    check("inject_lo", lo, 32'd111);

    issue(3'd6, 32'h5555_5555, 32'h6666_6666);
    check("rsv_done", 32'(done), 32'd0);
    check("rsv_busy", 32'(busy), 32'd0);
    check("rsv_hi", hi, mhi);
    check("rsv_lo", lo, mlo);

    run_div(3'd3, 32'd100, 32'd7, 1'b0);
    d1 = cyc;
    run_div(3'd3, 32'hFFFF_0000, 32'd3, 1'b0);
    d2 = cyc;
    check("b2b_gap", 32'(d2 - d1), 32'(W + 2));

    run_fast(3'd4, 32'h55, 32'd0);
    run_fast(3'd5, 32'h66, 32'd0);
    issue(3'd3, 32'd100, 32'd7);
    repeat (13) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    mhi = '0;
    mlo = '0;
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) begin
        check("arst_quiet", {30'd0, busy, done}, 32'd0);
        break;
      end
    end
    run_fast(3'd1, 32'd6, 32'd7);
    check("post_rst_lo", lo, 32'd42);
    check("post_rst_hi", hi, 32'd0);

    for (int i = 0; i < 30; i++) begin
      logic [2:0]   o;
      logic [W-1:0] a, b;
      o = 3'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'd1;
        3: b = b >> $urandom_range(8, 30);
        default: ;
      endcase
      if (o == 3'd2 || o == 3'd3) run_div(o, a, b, 1'b0);
      else run_fast(o, a, b);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check("rnd_idle_done", 32'(done), 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/mips_cpu_hilo_unit.md
Name: mips_cpu_hilo_unit

Overview:
Multi-cycle execution unit that owns the HI/LO register pair. It carries out the MULT, MULTU, DIV, DIVU, MTHI and MTLO requests issued by the instruction decoder.
Sits in the datapath beside the ALU and receives rs/rt operands from the register file. HI/LO are read back for MFHI/MFLO.
Multiply and move operations complete in one cycle. Division is iterative (restoring, one quotient bit per cycle), and the unit asserts busy so the core stalls.

Parameters:
WIDTH, 32, operand and HI/LO width. Iteration counter width is $clog2(WIDTH).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op_valid  input  1  request strobe, sampled on rising clk
op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved
rs_data  input  WIDTH  multiplicand / dividend / MTHI/MTLO source
rt_data  input  WIDTH  multiplier / divisor
hi  output  WIDTH  HI register (direct register output)
lo  output  WIDTH  LO register (direct register output)
busy  output  1  high while a divide is in progress; core stalls on it
done  output  1  one-cycle pulse in the cycle after HI and/or LO are written

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (reset).
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0, internal divide registers=0.
- Reset asserted mid-divide aborts the operation immediately. HI/LO return to 0, and no done pulse follows.
- States: IDLE, DIV_RUN, DIV_FIX. busy = (state != IDLE), driven from a register (not combinationally from op_valid).
- Request acceptance: an op is accepted only when op_valid=1 and state=IDLE at a rising edge.
  - op_valid while busy=1 is ignored. No queueing.
  - Reserved op codes 6-7 are ignored: no state change, no done.
- MTHI: hi <= rs_data at the accept edge; lo unchanged.
- MTLO: lo <= rs_data at the accept edge; hi unchanged.
- MULT: {hi,lo} <= signed(rs_data) * signed(rt_data), full 2*WIDTH product, written at the accept edge.
- MULTU: same as MULT with unsigned operands.
- For MTHI, MTLO, MULT and MULTU: busy never asserts, and done=1 in the following cycle.
- DIV/DIVU accept edge (edge 0):
  - Latch the operand magnitudes (absolute values for DIV, raw operands for DIVU).
  - Latch the quotient sign (rs[31]^rt[31], DIV only) and the remainder sign (rs[31], DIV only).
  - Clear the partial remainder, load counter=WIDTH-1, state -> DIV_RUN.
- DIV_RUN: one restoring step per cycle; shift in the next dividend bit, trial subtract, set the quotient bit. After the step with counter=0, state -> DIV_FIX.
- DIV_FIX: apply sign correction, write lo=quotient and hi=remainder, state -> IDLE.
- Divide timing:
  - busy is high for exactly WIDTH+1 cycles (33 at default).
  - HI/LO are updated at edge WIDTH+1. done pulses in the cycle after that edge, concurrent with busy=0.
- Signed divide result rules: the quotient truncates toward zero, and the remainder takes the sign of the dividend.
- Overflow, 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0 (the natural result of the magnitude arithmetic).
- Divide by zero (either DIV or DIVU): lo=0xFFFFFFFF, hi=rs_data. Latency is identical to a normal divide, with no early exit.
- A new request may be accepted in the cycle where done=1 (state is IDLE); back-to-back divides therefore issue every WIDTH+2 cycles.
- hi/lo hold their values in all cycles not listed above. Reads during DIV_RUN/DIV_FIX return the old values; the core is responsible for stalling MFHI/MFLO while busy=1.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFF1, done=1, busy never high. MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIVU rs=100, rt=7 -> busy high 33 cycles, then lo=14, hi=2, one-cycle done. DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Boundary divides:
  - DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU rs=0x1234, rt=0 -> lo=0xFFFFFFFF, hi=0x1234 after 33 busy cycles.
- MTHI 0xDEADBEEF then MTLO 0x0BADF00D on consecutive cycles -> hi=0xDEADBEEF, lo=0x0BADF00D, done pulses twice. During a DIVU, MTLO with op_valid=1 at cycle 10 is ignored; lo reflects only the divide result.
- Start DIVU 100/7, assert reset asynchronously at cycle 15 (mid-clock) -> hi=lo=0, busy=0 immediately, no done. Then MULTU 6*7 -> lo=42, hi=0.
- Reserved op=6 with op_valid=1 -> no change to hi/lo/busy, done stays 0. Back-to-back DIVU issued in the done cycle -> accepted; the second result appears WIDTH+2 cycles after the first.
